// File: rtl/mmio_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmio_controller                                              |
// | Description : Data-port steering between the CPU, data memory and a        |
// |               single memory-mapped device.                                 |
// |               - STATUS_ADDR is served locally, combinationally, no stall.  |
// |               - DATA_ADDR runs a req/ack handshake with the device and     |
// |                 stalls the CPU until the transfer completes.               |
// |               - Every other address passes straight through to memory.     |
// | Config      : `define MMIO_TIMEOUT_EN to abort device transfers that get   |
// |               no ack within TIMEOUT_CYCLES REQ cycles. The abort returns   |
// |               ERR_DATA and sets a sticky err status bit.                   |
// | Ports       : clk, reset (sync, active-high)                               |
// |               cpu_*   : CPU data port (addr/wdata/we/re in, rdata/stall out)|
// |               mem_*   : data memory port (gated for window addresses)      |
// |               dev_*   : device handshake (req/we/wdata out, ack/rdata in)  |
// |               dev_rx_valid_i : device "new data" pulse -> rx_pending       |
// | Status word : {29'b0, err, 1'b0, rx_pending}                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mmio_controller #(
  parameter logic [31:0] STATUS_ADDR    = 32'hFFFF8000,
  parameter logic [31:0] DATA_ADDR      = 32'hFFFF8004,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  // CPU data port
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic        cpu_re_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  // Data memory port
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i,
  // Device port
  output logic        dev_req_o,
  output logic        dev_we_o,
  output logic [31:0] dev_wdata_o,
  input  logic        dev_ack_i,
  input  logic [31:0] dev_rdata_i,
  input  logic        dev_rx_valid_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        dev_we_q, dev_we_d;
  logic [31:0] dev_wdata_q, dev_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rx_pending_q, rx_pending_d;

  logic        is_status;
  logic        is_data;
  logic        access;
  logic        status_wr;
  logic        dev_rd_done;
  logic        timeout_expire;
  logic        timeout_hit;
  logic        err_bit;

  assign is_status = (cpu_addr_i == STATUS_ADDR);
  assign is_data   = (cpu_addr_i == DATA_ADDR);
  assign access    = cpu_we_i | cpu_re_i;
  // A simultaneous we/re is treated as a store.
  assign status_wr = is_status & cpu_we_i;

  // Memory side: straight pass-through, strobes suppressed inside the window.
  assign mem_addr_o  = cpu_addr_i;
  assign mem_wdata_o = cpu_wdata_i;
  assign mem_we_o    = cpu_we_i & ~(is_status | is_data);
  assign mem_re_o    = cpu_re_i & ~(is_status | is_data);

  // Request is asserted for exactly the REQ residency, so a reset that
  // returns the FSM to IDLE also drops it on the next edge.
  assign dev_req_o   = (state_q == REQ);
  assign dev_we_o    = dev_we_q;
  assign dev_wdata_o = dev_wdata_q;

  // --------------------------------------------------------------------------
  // FSM next-state / outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    dev_we_d    = dev_we_q;
    dev_wdata_d = dev_wdata_q;
    rdata_d     = rdata_q;
    cpu_stall_o = 1'b0;
    dev_rd_done = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_data && access) begin
          // Stall in the same cycle the access is presented.
          cpu_stall_o = 1'b1;
          dev_we_d    = cpu_we_i;
          dev_wdata_d = cpu_wdata_i;
          state_d     = REQ;
        end
      end
      REQ: begin
        cpu_stall_o = 1'b1;
        // Ack is checked first so it wins over an expiring timeout.
        if (dev_ack_i) begin
          if (!dev_we_q) begin
            rdata_d = dev_rdata_i;
          end
          state_d = DONE;
        end else if (timeout_expire) begin
          rdata_d     = ERR_DATA;
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // CPU retires here; a completed device read consumes the pending data.
        dev_rd_done = ~dev_we_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Set has priority over either clear source.
  always_comb begin
    rx_pending_d = dev_rx_valid_i |
                   (rx_pending_q & ~((status_wr & cpu_wdata_i[0]) | dev_rd_done));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dev_we_q     <= 1'b0;
      dev_wdata_q  <= 32'h0;
      rdata_q      <= 32'h0;
      rx_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dev_we_q     <= dev_we_d;
      dev_wdata_q  <= dev_wdata_d;
      rdata_q      <= rdata_d;
      rx_pending_q <= rx_pending_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional REQ timeout
  // --------------------------------------------------------------------------
`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter holds the number of REQ cycles already elapsed; it reads
  // TIMEOUT_CYCLES-1 during the last permitted REQ cycle.
  always_comb begin
    cnt_d = (state_q == REQ) ? (cnt_q + CNT_W'(1)) : '0;
    err_d = timeout_hit | (err_q & ~(status_wr & cpu_wdata_i[2]));
  end

  assign timeout_expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_bit        = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_cfg;

  assign timeout_expire = 1'b0;
  assign err_bit        = 1'b0;
  assign unused_cfg     = ^{ERR_DATA, TIMEOUT_CYCLES, timeout_hit};
`endif

  // --------------------------------------------------------------------------
  // CPU read data
  // --------------------------------------------------------------------------
  always_comb begin
    if (state_q == DONE) begin
      cpu_rdata_o = rdata_q;
    end else if (is_status) begin
      cpu_rdata_o = {29'b0, err_bit, 1'b0, rx_pending_q};
    end else if (is_data) begin
      cpu_rdata_o = rdata_q;
    end else begin
      cpu_rdata_o = mem_rdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mmio_controller                                           |
// | Description : Self-checking bench for mmio_controller: table of single-    |
// |               cycle vectors, directed handshake sequences and randomized   |
// |               traffic against a transaction-level reference model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mmio_controller;

  localparam logic [31:0] STATUS = 32'hFFFF8000;
  localparam logic [31:0] DATA   = 32'hFFFF8004;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_we, cpu_re, cpu_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic        dev_req, dev_we, dev_ack, dev_rx_valid;
  logic [31:0] dev_wdata, dev_rdata;

  mmio_controller dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_addr_i     (cpu_addr),
    .cpu_wdata_i    (cpu_wdata),
    .cpu_we_i       (cpu_we),
    .cpu_re_i       (cpu_re),
    .cpu_rdata_o    (cpu_rdata),
    .cpu_stall_o    (cpu_stall),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_we_o       (mem_we),
    .mem_re_o       (mem_re),
    .mem_rdata_i    (mem_rdata),
    .dev_req_o      (dev_req),
    .dev_we_o       (dev_we),
    .dev_wdata_o    (dev_wdata),
    .dev_ack_i      (dev_ack),
    .dev_rdata_i    (dev_rdata),
    .dev_rx_valid_i (dev_rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: architectural status bits only.
  logic m_rx;
  logic m_err;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] mrd;
    logic [31:0] exp_rdata;
    logic        exp_stall;
    logic        exp_mwe;
    logic        exp_mre;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_addr     = 32'h0000_0100;
    cpu_wdata    = 32'h0;
    cpu_we       = 1'b0;
    cpu_re       = 1'b0;
    dev_ack      = 1'b0;
    dev_rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] status_word();
    return {29'b0, m_err, 1'b0, m_rx};
  endfunction

  task automatic status_read(input string name, input logic pulse);
    cpu_addr     = STATUS;
    cpu_re       = 1'b1;
    dev_rx_valid = pulse;
    @(negedge clk);
    chk({name, "_rdata"}, cpu_rdata, status_word());
    chk({name, "_stall"}, 32'(cpu_stall), 32'd0);
    chk({name, "_mre"}, 32'(mem_re), 32'd0);
    next_cycle();
    m_rx = m_rx | pulse;
    idle_inputs();
  endtask

  task automatic status_write(input string name, input logic [31:0] wd, input logic pulse);
    cpu_addr     = STATUS;
    cpu_we       = 1'b1;
    cpu_wdata    = wd;
    dev_rx_valid = pulse;
    @(negedge clk);
    chk({name, "_stall"}, 32'(cpu_stall), 32'd0);
    chk({name, "_mwe"}, 32'(mem_we), 32'd0);
    next_cycle();
    m_rx  = pulse | (m_rx & ~wd[0]);
    m_err = m_err & ~wd[2];
    idle_inputs();
  endtask

  // One device transfer; ack arrives in REQ cycle number 'delay' (1-based).
  task automatic dev_op(input string name, input logic we, input logic [31:0] wd,
                        input int delay, input logic [31:0] ack_data, input logic pulse);
    int  stall_cnt;
    logic req_ok;
    cpu_addr     = DATA;
    cpu_we       = we;
    cpu_re       = ~we;
    cpu_wdata    = wd;
    dev_rx_valid = pulse;
    @(negedge clk);
    chk({name, "_stall0"}, 32'(cpu_stall), 32'd1);
    chk({name, "_memstb"}, 32'(mem_we | mem_re), 32'd0);
    chk({name, "_req0"}, 32'(dev_req), 32'd0);
    next_cycle();
    dev_rx_valid = 1'b0;
    m_rx = m_rx | pulse;
    stall_cnt = 1;
    req_ok    = 1'b1;
    for (int k = 1; k <= delay; k++) begin
      dev_ack   = (k == delay);
      dev_rdata = (k == delay) ? ack_data : $urandom;
      @(negedge clk);
      if (cpu_stall) stall_cnt++;
      if (!dev_req) req_ok = 1'b0;
      if (k == 1) begin
        chk({name, "_devwe"}, 32'(dev_we), 32'(we));
        if (we) chk({name, "_devwdata"}, dev_wdata, wd);
      end
      next_cycle();
      dev_ack = 1'b0;
    end
    chk({name, "_stallcycles"}, 32'(stall_cnt), 32'(delay + 1));
    chk({name, "_reqheld"}, 32'(req_ok), 32'd1);
    @(negedge clk);
    chk({name, "_retire_stall"}, 32'(cpu_stall), 32'd0);
    chk({name, "_retire_req"}, 32'(dev_req), 32'd0);
    if (!we) chk({name, "_rdata"}, cpu_rdata, ack_data);
    next_cycle();
    if (!we) m_rx = 1'b0;
    idle_inputs();
  endtask

  vec_t vecs[6];

  initial begin
    logic [31:0] a, d, r;
    int          op;
    logic        p;

    idle_inputs();
    reset     = 1'b1;
    mem_rdata = 32'h0;
    dev_rdata = 32'h0;
    m_rx      = 1'b0;
    m_err     = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_req", 32'(dev_req), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_devwe", 32'(dev_we), 32'd0);
    chk("rst_devwdata", dev_wdata, 32'd0);
    next_cycle();
    reset = 1'b0;
    status_read("rst_status", 1'b0);

    // ---------------- table-driven single-cycle vectors ----------------
    vecs[0] = '{"mem_load",   32'h0000_1000, 32'h0,  1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"mem_store",  32'h0000_2000, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h1111_2222, 32'h1111_2222, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"mem_we_re",  32'h0000_3000, 32'h5,  1'b1, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{"stat_rd",    STATUS,        32'h0,  1'b0, 1'b1, 32'h9999_9999, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"stat_wr0",   STATUS,        32'h0,  1'b1, 1'b0, 32'h9999_9999, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"no_access",  32'hFFFF_8008, 32'h0,  1'b0, 1'b0, 32'h7777_0000, 32'h7777_0000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      cpu_addr  = vecs[i].addr;
      cpu_wdata = vecs[i].wdata;
      cpu_we    = vecs[i].we;
      cpu_re    = vecs[i].re;
      mem_rdata = vecs[i].mrd;
      @(negedge clk);
      chk({vecs[i].name, "_rdata"}, cpu_rdata, vecs[i].exp_rdata);
      chk({vecs[i].name, "_stall"}, 32'(cpu_stall), 32'(vecs[i].exp_stall));
      chk({vecs[i].name, "_mwe"}, 32'(mem_we), 32'(vecs[i].exp_mwe));
      chk({vecs[i].name, "_mre"}, 32'(mem_re), 32'(vecs[i].exp_mre));
      chk({vecs[i].name, "_maddr"}, mem_addr, vecs[i].addr);
      chk({vecs[i].name, "_mwdata"}, mem_wdata, vecs[i].wdata);
      next_cycle();
    end
    idle_inputs();

    // ---------------- directed device sequences ----------------
    dev_op("store_aa", 1'b1, 32'h0000_00AA, 3, 32'h0, 1'b0);
    dev_rx_valid = 1'b1;
    next_cycle();
    dev_rx_valid = 1'b0;
    m_rx = 1'b1;
    status_read("rx_set", 1'b0);
    dev_op("load_55", 1'b0, 32'h0, 2, 32'h0000_0055, 1'b0);
    status_read("rx_clr_by_read", 1'b0);
    dev_op("load_fast", 1'b0, 32'h0, 1, 32'h0BAD_CAFE, 1'b0);

    // Set wins over a simultaneous software clear.
    status_write("set_vs_clr", 32'h1, 1'b1);
    status_read("set_vs_clr_rd", 1'b0);
    status_write("sw_clear", 32'h1, 1'b0);
    status_read("sw_clear_rd", 1'b0);

    // Stray ack while idle is ignored.
    dev_ack   = 1'b1;
    dev_rdata = 32'h1357_9BDF;
    next_cycle();
    dev_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_req", 32'(dev_req), 32'd0);
    chk("stray_ack_stall", 32'(cpu_stall), 32'd0);
    next_cycle();

    // Reset while in REQ, ack one cycle later.
    cpu_addr = DATA;
    cpu_re   = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rstreq_inreq", 32'(dev_req), 32'd1);
    reset = 1'b1;
    next_cycle();
    reset     = 1'b0;
    idle_inputs();
    dev_ack   = 1'b1;
    dev_rdata = 32'h0000_0077;
    m_rx      = 1'b0;
    m_err     = 1'b0;
    @(negedge clk);
    chk("rstreq_req", 32'(dev_req), 32'd0);
    chk("rstreq_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    dev_ack = 1'b0;
    @(negedge clk);
    chk("rstreq_still_idle", 32'(dev_req), 32'd0);
    next_cycle();
    dev_op("after_rst_load", 1'b0, 32'h0, 2, 32'h2468_ACE0, 1'b0);

`ifdef MMIO_TIMEOUT_EN
    // No ack: 255 REQ cycles, then abort with ERR_DATA.
    begin
      int held;
      cpu_addr = DATA;
      cpu_re   = 1'b1;
      next_cycle();
      held = 0;
      for (int k = 1; k <= 255; k++) begin
        @(negedge clk);
        if (cpu_stall && dev_req) held++;
        next_cycle();
      end
      chk("to_held", 32'(held), 32'd255);
      @(negedge clk);
      chk("to_stall", 32'(cpu_stall), 32'd0);
      chk("to_rdata", cpu_rdata, 32'hDEAD_BEEF);
      next_cycle();
      idle_inputs();
      m_err = 1'b1;
      m_rx  = 1'b0;
    end
    status_read("to_err", 1'b0);
    status_write("to_clr", 32'h4, 1'b0);
    status_read("to_err_clr", 1'b0);
    dev_op("ack_on_expiry", 1'b0, 32'h0, 255, 32'h1122_3344, 1'b0);
    status_read("expiry_no_err", 1'b0);
`else
    dev_op("long_wait", 1'b0, 32'h0, 300, 32'h5566_7788, 1'b0);
    status_read("long_wait_no_err", 1'b0);
`endif

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 4);
      p  = ($urandom_range(0, 3) == 0);
      d  = $urandom;
      case (op)
        0, 1: begin
          a = $urandom & 32'h7FFF_FFFC;
          r = $urandom;
          cpu_addr     = a;
          cpu_wdata    = d;
          cpu_we       = (op == 1);
          cpu_re       = (op == 0);
          mem_rdata    = r;
          dev_rx_valid = p;
          @(negedge clk);
          chk("rnd_mem_stall", 32'(cpu_stall), 32'd0);
          chk("rnd_mem_we", 32'(mem_we), 32'(op == 1));
          chk("rnd_mem_re", 32'(mem_re), 32'(op == 0));
          if (op == 0) chk("rnd_mem_rdata", cpu_rdata, r);
          else         chk("rnd_mem_wdata", mem_wdata, d);
          next_cycle();
          m_rx = m_rx | p;
          idle_inputs();
        end
        2: status_read("rnd_stat_rd", p);
        3: status_write("rnd_stat_wr", d, p);
        default: dev_op("rnd_dev", d[31], $urandom, $urandom_range(1, 4), $urandom, p);
      endcase
    end
    status_read("final_status", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
